// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB-first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with parity_err; otherwise 8N1.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s to fall
// START     | timing to start-bit centre, rejecting glitches
// DATA      | sampling 8 data bits at bit centres
// PARITY    | sampling even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling stop bit, then one cycle to deliver result
// WAIT_IDLE | framing error seen, waiting for line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [12:0] BIT_TC  = 13'(CLKS_PER_BIT - 1);
  localparam logic [12:0] HALF_TC = 13'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  sync;
  logic        rx_s;
  logic [12:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        stop_done, stop_bit;
  logic        bit_tick, half_tick;
  logic        cnt_clr, cnt_run, shift_en, stop_en, deliver_ok, deliver_bad;
`ifdef UART_RX_PARITY_EN
  logic        par_en, par_bad;
`endif

  assign rx_s      = sync[1];
  assign bit_tick  = (cnt == BIT_TC);
  assign half_tick = (cnt == HALF_TC);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx_in};
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_run     = 1'b0;
    shift_en    = 1'b0;
    stop_en     = 1'b0;
    deliver_ok  = 1'b0;
    deliver_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        cnt_run = 1'b1;
        if (half_tick) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_run = 1'b1;
        if (bit_tick) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_run = 1'b1;
        if (bit_tick) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        cnt_run = !stop_done;
        // Result is delivered the cycle after the stop sample.
        if (stop_done) begin
          if (stop_bit) begin
            deliver_ok = 1'b1;
            state_nxt  = IDLE;
          end else begin
            deliver_bad = 1'b1;
            state_nxt   = WAIT_IDLE;
          end
        end else if (bit_tick) begin
          cnt_clr = 1'b1;
          stop_en = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt       <= 13'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      stop_done <= 1'b0;
      stop_bit  <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= 13'd0;
      else if (cnt_run) cnt <= cnt + 13'd1;
      if (state == IDLE)  bit_idx <= 3'd0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
      if (stop_en) begin
        stop_bit  <= rx_s;
        stop_done <= 1'b1;
      end else if (deliver_ok || deliver_bad) begin
        stop_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (deliver_ok) rx_data <= shift;
      rx_valid  <= deliver_ok;
      frame_err <= deliver_bad;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bad <= (^shift) ^ rx_s;
      parity_err <= deliver_ok & par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames with a timing-aware scoreboard,
// plus hand sequences for false start, framing error and reset mid-byte.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = HALF + 10 * C + 1;
`else
  localparam int LAT  = HALF + 9 * C + 1;
`endif

  logic       clk_in = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  logic [7:0] last_data;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (C) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    exp_t e;
    e.cyc   = cyc + 3 + LAT;
    e.data  = data;
    e.valid = stop;
    e.ferr  = !stop;
`ifdef UART_RX_PARITY_EN
    e.perr  = stop & ((^data) ^ par);
`else
    e.perr  = 1'b0;
`endif
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
  endtask

  initial begin
    int d;
    logic prev_pulse;
    exp_t e;

    vecs.push_back('{data: 8'hA5, par: ^8'hA5, stop: 1'b1, gap: 2});
    vecs.push_back('{data: 8'h00, par: 1'b0,   stop: 1'b1, gap: 0});
    vecs.push_back('{data: 8'hFF, par: 1'b0,   stop: 1'b1, gap: 0});
    vecs.push_back('{data: 8'h3C, par: 1'b0,   stop: 1'b1, gap: 2});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{data: 8'h07, par: 1'b1,   stop: 1'b1, gap: 2});
    vecs.push_back('{data: 8'h07, par: 1'b0,   stop: 1'b1, gap: 2});
`endif

    rx_in      = 1'b1;
    reset      = 1'b1;
    last_data  = 8'h00;
    prev_pulse = 1'b0;

    fork
      forever begin
        @(negedge clk_in);
        if (reset) begin
          last_data  = 8'h00;
          prev_pulse = 1'b0;
        end else if (rx_valid || frame_err || parity_err) begin
          chk("pulse_width", int'(prev_pulse), 0);
          chk("valid_with_ferr", int'(rx_valid && frame_err), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("rx_valid", int'(rx_valid), int'(e.valid));
            chk("frame_err", int'(frame_err), int'(e.ferr));
            chk("parity_err", int'(parity_err), int'(e.perr));
            if (e.valid) last_data = e.data;
            chk("rx_data", int'(rx_data), int'(last_data));
          end
          prev_pulse = 1'b1;
        end else begin
          prev_pulse = 1'b0;
        end
      end
    join_none

    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_parity_err", int'(parity_err), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (2 * C) @(posedge clk_in);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      for (int g = 0; g < vecs[i].gap; g++) drive_bit(1'b1);
    end

    // Framing error followed by a long break, then a good byte.
    send_frame(8'h55, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (40 * C) @(posedge clk_in);
    #1;
    chk("break_busy_held", int'(busy), 1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("break_released_busy", int'(busy), 0);
    send_frame(8'h12, ^8'h12, 1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // False start: 6 low cycles, decision at t=HALF.
    rx_in = 1'b0;
    d = cyc;
    repeat (5) @(posedge clk_in);
    #1;
    chk("false_start_busy_t2", int'(busy), 1);
    @(posedge clk_in);
    #1;
    rx_in = 1'b1;
    repeat (d + 12 - cyc) @(posedge clk_in);
    #1;
    chk("false_start_busy_t9", int'(busy), 0);
    drive_bit(1'b1);
    drive_bit(1'b1);

    // Reset after 4 data bits of 0xC3.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 8'h00);
    reset = 1'b1;
    rx_in = 1'b1;
    #1;
    chk("midreset_rx_data", int'(rx_data), 0);
    chk("midreset_rx_valid", int'(rx_valid), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    chk("midreset_parity_err", int'(parity_err), 0);
    chk("midreset_busy", int'(busy), 0);
    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h81, ^8'h81, 1'b1);
    repeat (4) drive_bit(1'b1);

    chk("final_rx_data", int'(rx_data), 8'h81);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART serial receiver, 8 data bits LSB-first, one stop bit, optional even parity. Oversamples the asynchronous `rx_in` line with the system clock, samples each bit at its centre, and delivers each byte as a one-cycle `rx_valid` pulse with error flags. It is the receive counterpart to the 9600-baud transmit path and runs from the same 50 MHz system clock.

## Interface
- `CLKS_PER_BIT`, default 5208: system clocks per bit (50 MHz / 9600). Legal range is 8..8191, held in a 13-bit counter.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (integer): offset from the start edge to the start-bit centre.

Ports:
- `clk_in`: input, 1 bit. System clock; all logic is on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high. Clears all state.
- `rx_in`: input, 1 bit. Serial line, idle high, asynchronous to `clk_in`.
- `rx_data`: output, 8 bits. Last received byte. Holds its value until the next byte completes.
- `rx_valid`: output, 1 bit. One-cycle pulse when `rx_data` is updated.
- `frame_err`: output, 1 bit. One-cycle pulse when the stop bit is sampled low.
- `parity_err`: output, 1 bit. One-cycle pulse, coincident with `rx_valid`, when parity fails. Tied 0 when parity is not compiled in.
- `busy`: output, 1 bit. High in every state other than IDLE.

## Operation
- **Synchronizer.** `rx_in` passes through 2 flops to give `rx_s`; both flops reset to 1. Only `rx_s` is used downstream.
- **State machine:** IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_IDLE.
- **IDLE.** On `rx_s == 0`, go to START and clear the bit counter. That clock edge is t=0.
- **START.**
  - At t=HALF_BIT, sample `rx_s`.
  - If the sample is 1, it is a false start: return to IDLE with no outputs pulsed.
  - If the sample is 0, go to DATA and reload the bit counter.
- **DATA.** Data bit k (k=0..7) is sampled at t=HALF_BIT+(k+1)·CLKS_PER_BIT and shifted in LSB-first. After k=7, go to PARITY, or to STOP when parity is not compiled in.
- **PARITY.**
  - Sampled at t=HALF_BIT+9·CLKS_PER_BIT.
  - Error if the XOR of the 8 data bits and the parity bit is 1 (even parity).
- **STOP.** Sampled at t=HALF_BIT+9·CLKS_PER_BIT without parity, or +10·CLKS_PER_BIT with parity.
  - Stop = 1: next cycle, update `rx_data`, pulse `rx_valid` (and `parity_err` if flagged), then go to IDLE.
  - Stop = 0: next cycle, pulse `frame_err`. `rx_data` is not updated and `rx_valid` is not pulsed. Go to WAIT_IDLE.
- **WAIT_IDLE.** Stay until `rx_s == 1`, then go to IDLE. This stops a break condition from retriggering.
- **Back-to-back frames.** A new start edge is accepted from the first IDLE cycle after STOP. Because the stop sample falls at mid-bit, the next start edge is never missed.
- **Bit counter.** 13-bit. Reloads to 0 on each sample. It does not wrap within a frame.

## Timing
- **Reset values:** `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE, synchronizer=2'b11.
- **Reset mid-frame:** all outputs return to their reset values immediately. The partial byte is discarded. After release the block waits in IDLE for a fresh falling edge.
- **Latency:** `rx_valid` rises HALF_BIT+9·CLKS_PER_BIT+1 cycles after t=0 (+CLKS_PER_BIT with parity). t=0 itself is 2–3 `clk_in` edges after the line falls.
- **Pulse width:** `rx_valid`, `frame_err` and `parity_err` are each exactly 1 cycle. `rx_valid` and `frame_err` are never high in the same cycle.
- **Flow control:** none. The consumer must capture `rx_data` before the next `rx_valid`, which is at least 10·CLKS_PER_BIT cycles later.
- **Registering:** all outputs are registered.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frame is 8E1. The PARITY state exists, `parity_err` is driven, and a frame is 11 bits.
- **Undefined:** frame is 8N1. PARITY is never entered, `parity_err` is a constant 0, and a frame is 10 bits.

## Test plan
The bench uses CLKS_PER_BIT=16.
- **Single byte:** send 0xA5 (8N1) → exactly one `rx_valid` pulse at t=HALF_BIT+9·16+1 = 153, with `rx_data`=0xA5 and `frame_err`=0.
- **Back-to-back bytes:** send 0x00, 0xFF, 0x3C with no idle gap → three `rx_valid` pulses exactly 160 cycles apart carrying the correct bytes.
- **False start:** drive the line low for 6 cycles, then high → no output pulses, `busy` returns to 0 by t=9.
- **Framing error:** send 0x55 with the stop bit low and hold the line low for 40 more bit times → one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, state held in WAIT_IDLE until the line rises. A following byte 0x12 is then received correctly.
- **Reset mid-byte:** assert `reset` after 4 data bits of 0xC3 → all outputs return to reset values at once. After release, the next full 0x81 frame gives `rx_data`=0x81.
- **Parity (with `UART_RX_PARITY_EN`):** 0x07 with parity bit 1 → `rx_valid` with `parity_err`=0. The same byte with parity bit 0 → `rx_valid` and `parity_err` high in the same cycle.
